// File: rtl/huffman_pkg.sv
// Shared widths, FSM state type and length clamp for the DEFLATE bit packer.
package huffman_pkg;
  localparam int CODE_W = 16;
  localparam int BITS_W = 5;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = 6;

  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} pack_state_t;

  // Lengths beyond a full codeword saturate rather than wrap.
  function automatic logic [BITS_W-1:0] clamp_bits(input logic [BITS_W-1:0] b);
    return (b > BITS_W'(CODE_W)) ? BITS_W'(CODE_W) : b;
  endfunction
endpackage

// File: rtl/code_bit_reverse.sv
// Variable-length codeword reversal: rev[i] = code[bits-1-i] for i < bits, zero above.
module code_bit_reverse
  import huffman_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic [BITS_W-1:0] bits,
  output logic [CODE_W-1:0] rev
);
  logic [CODE_W-1:0] full;

  for (genvar i = 0; i < CODE_W; i++) begin : g_rev
    assign full[i] = code[CODE_W-1-i];
  end

  // Right-justify the reversed field; bits above the length fall off the bottom.
  assign rev = full >> (BITS_W'(CODE_W) - bits);
endmodule

// File: rtl/huffman_bit_packer.sv
// LSB-first codeword-to-byte packer with 32-bit accumulator and flush/pad.
// HUFFMAN_CODE_REVERSE_EN: insert codewords MSB-first (Huffman code order).
module huffman_bit_packer
  import huffman_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_data,
  input  logic [BITS_W-1:0] in_bits,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic              flush_done
);
  pack_state_t       state, state_next;
  logic [ACC_W-1:0]  acc, acc_shift, acc_next;
  logic [CNT_W-1:0]  cnt, cnt_eff, cnt_next;
  logic [BITS_W-1:0] bits_c;
  logic [CODE_W-1:0] code_ins;
  logic              push, pop, done_now, flush_done_q;

  assign bits_c = clamp_bits(in_bits);

`ifdef HUFFMAN_CODE_REVERSE_EN
  code_bit_reverse u_rev (.code(in_data), .bits(bits_c), .rev(code_ins));
`else
  logic [CODE_W-1:0] mask;
  assign mask     = (CODE_W'(1) << bits_c) - CODE_W'(1);
  assign code_ins = in_data & mask;
`endif

  assign in_ready   = (state == RUN) && (cnt <= CNT_W'(16));
  assign out_valid  = (state == RUN) ? (cnt >= CNT_W'(8)) : (cnt != '0);
  assign out_last   = (state == FLUSH) && (cnt != '0) && (cnt < CNT_W'(8));
  assign out_byte   = acc[7:0];
  assign flush_done = flush_done_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Shift out first, then insert at the post-pop fill level.
  assign cnt_eff   = pop ? ((cnt >= CNT_W'(8)) ? cnt - CNT_W'(8) : '0) : cnt;
  assign acc_shift = pop ? (acc >> 8) : acc;
  assign acc_next  = acc_shift | (push ? (ACC_W'(code_ins) << cnt_eff) : '0);
  assign cnt_next  = cnt_eff + (push ? CNT_W'(bits_c) : '0);

  assign done_now = (state == FLUSH) && ((cnt == '0) || (pop && cnt < CNT_W'(8)));

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush)    state_next = FLUSH;
      FLUSH:   if (done_now) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      acc          <= '0;
      cnt          <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state        <= state_next;
      acc          <= acc_next;
      cnt          <= cnt_next;
      flush_done_q <= done_now;
    end
  end
endmodule

// File: doc/huffman_bit_packer.md
# huffman_bit_packer

- Serialises variable-length codewords (0–16 bits, valid-bit count attached) from the static Huffman encoder into a contiguous byte stream for the DEFLATE output path.
- Bits are packed LSB-first into each output byte, per DEFLATE bit order.
- Holds up to 32 pending bits, applies ready/valid backpressure in both directions, and pads with zeros and marks the last byte on a flush request.
- Sits directly downstream of the Huffman encoder and upstream of the byte-oriented output FIFO.

## Interface
- Parameters: none; widths are fixed constants in the shared package.
- Clocking/reset (already decided): one clock, `clock`; reset `reset_n`, asynchronous, active-low.
- `clock`  in  1  rising-edge clock for all state.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  codeword present on `in_data`/`in_bits`.
- `in_ready`  out  1  packer accepts a codeword this cycle.
- `in_data`  in  16  codeword, right-justified; bits at and above `in_bits` are ignored.
- `in_bits`  in  5  codeword length, 0..16; values 17..31 are clamped to 16.
- `flush`  in  1  end-of-block request: pad and drain the buffer.
- `out_valid`  out  1  `out_byte` holds a complete (or final padded) byte.
- `out_ready`  in  1  downstream accepts `out_byte`.
- `out_byte`  out  8  next stream byte; bit 0 is the first bit in the stream.
- `out_last`  out  1  qualifies `out_byte` as the final padded byte of a flush.
- `flush_done`  out  1  one-cycle pulse when a flush has completed.

## Operation
- Buffer:
  - 32-bit accumulator `acc`; stream bit k is `acc[k]`.
  - 6-bit count `cnt` (0..32).
- Input handshake:
  - `in_ready = (state==RUN) && (cnt <= 16)`.
  - A transfer occurs on `in_valid && in_ready`.
  - Bits are masked to `in_bits` and OR'd into `acc` starting at position `cnt_eff`.
  - `cnt_eff = cnt - 8` if an output pop happens in the same cycle, else `cnt`.
- Output:
  - `out_byte = acc[7:0]`.
  - In RUN: `out_valid = (cnt >= 8)`.
  - A pop on `out_valid && out_ready` shifts `acc` right by 8 (zero fill) and reduces `cnt` by 8.
- Simultaneous pop and push in one cycle:
  - Shift first, then insert.
  - `cnt_next = cnt - 8 + in_bits`.
- `in_bits == 0` with `in_valid`: the handshake completes and nothing is inserted.
- FSM `RUN` -> `FLUSH` -> `RUN`:
  - RUN: `flush` is sampled each cycle. If `in_valid && in_ready` is also true that cycle, the codeword is accepted first, then the FSM enters FLUSH. `flush` is ignored outside RUN.
  - FLUSH, `cnt >= 8`: `in_ready = 0`; full bytes are emitted as in RUN with `out_last = 0`.
  - FLUSH, `cnt` in 1..7: `out_valid = 1`, `out_byte = acc[7:0]` with the upper bits zero, `out_last = 1`. On the pop, `cnt = 0`, `flush_done` pulses and the FSM returns to RUN.
  - FLUSH, `cnt == 0`: no byte is emitted; `flush_done` pulses and the FSM returns to RUN on the next edge.
  - A buffer that is an exact byte multiple ends without an `out_last` byte. `flush_done` marks the block end.
- Reset mid-operation: `acc` and `cnt` are cleared, the FSM goes to RUN, and pending bits are discarded.

## Timing
- Reset values:
  - `acc = 0`, `cnt = 0`, state RUN.
  - `in_ready = 1`.
  - `out_valid = 0`, `out_byte = 0`, `out_last = 0`, `flush_done = 0`.
- All outputs are decoded from registers; there are no combinational in->out paths except the `out_ready`/`in_valid` effects on next-state.
- Latency: a codeword completing a byte at edge N gives `out_valid` high in cycle N+1.
- Throughput:
  - One codeword per cycle while `cnt <= 16`.
  - One byte per cycle out.
  - Sustained 16-bit input therefore stalls by design.
- Flush of a 1..7-bit remainder: `out_last` byte appears 1 cycle after the flush edge; `flush_done` fires on its pop edge.

## Configuration
- `HUFFMAN_CODE_REVERSE_EN` defined:
  - Each codeword is inserted MSB-first: `in_data[in_bits-1]` lands at stream position `cnt_eff`.
  - This matches DEFLATE Huffman code order.
- Undefined:
  - Codewords are inserted LSB-first: `in_data[0]` lands at `cnt_eff`.
  - This is used for extra-bit fields and raw stored blocks.

## Structure
- Package `huffman_pkg`:
  - `CODE_W = 16`, `BITS_W = 5`, `ACC_W = 32`, `CNT_W = 6`.
  - State enum `pack_state_t {RUN, FLUSH}`.
- Sub-module `code_bit_reverse`: combinational variable-length reversal of `in_data` over `in_bits`, instantiated only under `HUFFMAN_CODE_REVERSE_EN`.

## Test plan
- Reset, then idle: `in_ready = 1`, `out_valid = 0`, `out_byte = 0x00`.
- Macro on; code `0x030`, 8 bits (literal 0); `out_ready = 1` -> one byte `0x0C`, `out_last = 0`. Macro off -> `0x30`.
- Macro on; code `0x190`, 9 bits, then `flush` -> bytes `0x13` then `0x00` with `out_last = 1`; `flush_done` pulses after the second pop.
- `out_ready = 0`; feed four 16-bit codes back to back -> first two accepted, `in_ready = 0` at `cnt = 32`. Release `out_ready` -> 4 bytes drain in order, then inputs resume.
- Simultaneous pop and push: with `cnt = 12`, a pop plus a 7-bit code in one cycle -> `cnt = 11`, and the new bits start at stream position 4 of the shifted `acc`.
- Assert `reset_n` low mid-FLUSH with `cnt = 5` -> all outputs reset immediately; no `out_last` byte and no `flush_done`.
